// File: rtl/rng_sop_dispatch_if.sv
// Handshake bundle between the RNG SOP source, the dispatcher and its consumer channels.
interface rng_sop_dispatch_if #(
  parameter int SRC_W = 128,
  parameter int OUT_W = 32,
  parameter int NCH   = 2
);
  logic             sop_valid;
  logic [SRC_W-1:0] sop_data;
  logic             rd_sop;
  logic [NCH-1:0]   ch_req;
  logic [NCH-1:0]   ch_ack;
  logic [OUT_W-1:0] ch_data;

  modport master (
    output sop_valid, sop_data, ch_req,
    input  rd_sop, ch_ack, ch_data
  );

  modport slave (
    input  sop_valid, sop_data, ch_req,
    output rd_sop, ch_ack, ch_data
  );
endinterface

// File: rtl/rng_sop_dispatch.sv
// Pre-fetches RNG words into a small FIFO and hands out OUT_W-bit slices to NCH
// consumers in round-robin order; each slice is delivered exactly once.
//
//  state      | meaning
//  FETCH_IDLE | no request in flight; rd_sop may issue
//  FETCH_WAIT | request in flight; next sop_valid is pushed
//  FETCH_DROP | request in flight but flushed; next sop_valid is dropped
module rng_sop_dispatch #(
  parameter int SRC_W = 128,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4,
  parameter int NCH   = 2
) (
  input  logic                       rng_clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       flush,
  rng_sop_dispatch_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       src_err
);
  localparam int RATIO = SRC_W / OUT_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_DROP
  } fetch_t;

  fetch_t state, state_nxt;

  logic [SRC_W-1:0]             mem [DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [SW-1:0]                sub_idx;
  logic [PW-1:0]                rr_ptr, grant_idx, next_rr, cand_idx;
  logic [RATIO-1:0][OUT_W-1:0]  head;
  logic                         grant, push, pop, issue, unsolicited, rd_sop_q;
  int                           cand;

  assign head        = mem[rd_ptr];
  assign push        = bus.sop_valid && (state == FETCH_WAIT) && !flush;
  assign unsolicited = bus.sop_valid && (state == FETCH_IDLE);
  assign issue       = enable && (state == FETCH_IDLE) && !flush && (level < LW'(DEPTH));
  assign pop         = grant && (sub_idx == SW'(RATIO - 1));
  assign next_rr     = (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
  assign bus.rd_sop  = rd_sop_q;

  // Round-robin search starting at rr_ptr; the first requester found wins.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    if ((level != '0) && !flush) begin
      for (int k = 0; k < NCH; k++) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NCH) cand = cand - NCH;
        cand_idx = PW'(cand);
        if (!grant && bus.ch_req[cand_idx]) begin
          grant     = 1'b1;
          grant_idx = cand_idx;
        end
      end
    end
  end

  always_comb begin
    bus.ch_ack  = '0;
    bus.ch_data = '0;
    if (grant) begin
      bus.ch_ack[grant_idx] = 1'b1;
      bus.ch_data           = head[sub_idx];
    end
  end

  // A flush while waiting parks in FETCH_DROP so the late word cannot land in the emptied FIFO.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_IDLE: if (issue) state_nxt = FETCH_WAIT;
      FETCH_WAIT: begin
        if (bus.sop_valid) state_nxt = FETCH_IDLE;
        else if (flush)    state_nxt = FETCH_DROP;
      end
      FETCH_DROP: if (bus.sop_valid) state_nxt = FETCH_IDLE;
      default:    state_nxt = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_IDLE;
      rd_sop_q <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sub_idx  <= '0;
      rr_ptr   <= '0;
      level    <= '0;
      src_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_sop_q <= issue;
      if (grant) rr_ptr <= next_rr;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        sub_idx <= '0;
        level   <= '0;
        src_err <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (grant) sub_idx <= pop ? '0 : sub_idx + 1'b1;
        if (push && !pop)      level <= level + 1'b1;
        else if (pop && !push) level <= level - 1'b1;
        if (unsolicited) src_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge rng_clk) begin
    if (push) mem[wr_ptr] <= bus.sop_data;
  end
endmodule

// File: tb/tb_rng_sop_dispatch.sv
// Self-checking bench for rng_sop_dispatch: a per-cycle vector table followed by
// scoreboarded fill/drain runs against a behavioural RNG and a reset-during-fetch case.
module tb_rng_sop_dispatch;
  localparam int SRC_W = 128;
  localparam int OUT_W = 32;
  localparam int DEPTH = 4;
  localparam int NCH   = 2;
  localparam int RATIO = SRC_W / OUT_W;

  localparam logic [127:0] W1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] W2 = 128'hDEADBEEF_0BADF00D_CAFEF00D_FEEDFACE;
  localparam logic [127:0] W3 = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] level;
  logic       src_err;

  always #5 clk = ~clk;

  rng_sop_dispatch_if #(.SRC_W(SRC_W), .OUT_W(OUT_W), .NCH(NCH)) bus ();

  rng_sop_dispatch #(.SRC_W(SRC_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .rng_clk (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .flush   (flush),
    .bus     (bus),
    .level   (level),
    .src_err (src_err)
  );

  typedef struct {
    logic         en, fl, sv;
    logic [127:0] data;
    logic [1:0]   req;
    logic         x_rd;
    logic [1:0]   x_ack;
    logic [31:0]  x_data;
    logic [2:0]   x_lvl;
    logic         x_err;
  } vec_t;

  vec_t tbl[$];

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard / model state
  logic [31:0] exp_q[$];
  int  lvl_m, sub_m, rr_m, pend, lat, cnt_rd, words_sent;
  int  cnt_ch[NCH];
  bit  out_m, rd_m, sb_on, rng_on;

  function automatic vec_t mk(input logic en, input logic fl, input logic sv,
                              input logic [127:0] data, input logic [1:0] req,
                              input logic x_rd, input logic [1:0] x_ack,
                              input logic [31:0] x_data, input logic [2:0] x_lvl,
                              input logic x_err);
    vec_t v;
    v.en = en; v.fl = fl; v.sv = sv; v.data = data; v.req = req;
    v.x_rd = x_rd; v.x_ack = x_ack; v.x_data = x_data; v.x_lvl = x_lvl; v.x_err = x_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    lvl_m = 0; sub_m = 0; rr_m = 0; pend = 0; cnt_rd = 0; words_sent = 0;
    out_m = 0; rd_m = 0;
    for (int c = 0; c < NCH; c++) cnt_ch[c] = 0;
  endtask

  task automatic monitor();
    logic [NCH-1:0] xa;
    int  ch;
    bit  any, push, pop, rdn;
    check("rd_sop", bus.rd_sop, rd_m);
    check("level", level, lvl_m);
    any = (lvl_m != 0) && !flush && (bus.ch_req != '0);
    ch  = 0;
    xa  = '0;
    if (any) begin
      for (int k = NCH - 1; k >= 0; k--)
        if (bus.ch_req[(rr_m + k) % NCH]) ch = (rr_m + k) % NCH;
      xa[ch] = 1'b1;
    end
    check("ch_ack", bus.ch_ack, xa);
    if (any) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got ack %0h, expected no pending slice", bus.ch_ack);
      end else begin
        check("ch_data", bus.ch_data, exp_q.pop_front());
        cnt_ch[ch]++;
      end
    end else begin
      check("ch_data_idle", bus.ch_data, 0);
    end
    push = bus.sop_valid && out_m && !flush;
    pop  = any && (sub_m == RATIO - 1);
    rdn  = enable && !out_m && !flush && (lvl_m < DEPTH);
    if (any) begin
      sub_m = pop ? 0 : sub_m + 1;
      rr_m  = (ch + 1) % NCH;
    end
    lvl_m = lvl_m + int'(push) - int'(pop);
    out_m = (out_m && !bus.sop_valid) || rdn;
    rd_m  = rdn;
  endtask

  // One clock: sample at negedge, then drive the RNG response just after posedge.
  task automatic step();
    logic [127:0] w;
    @(negedge clk);
    if (rng_on && bus.rd_sop) begin
      check("rd_overlap_pend", pend, 0);
      cnt_rd++;
      pend = lat;
    end
    if (sb_on) monitor();
    @(posedge clk);
    #1;
    bus.sop_valid = 1'b0;
    if (rng_on && pend > 0) begin
      pend--;
      if (pend == 0) begin
        w = {$urandom, $urandom, $urandom, $urandom};
        bus.sop_valid = 1'b1;
        bus.sop_data  = w;
        words_sent++;
        for (int k = 0; k < RATIO; k++) exp_q.push_back(w[k*OUT_W +: OUT_W]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    bus.sop_valid = 1'b0;
    bus.sop_data  = '0;
    bus.ch_req    = '0;
    sb_on = 0; rng_on = 0; lat = 3;
    model_reset();

    //              en fl sv data req   rd ack    data          lvl err
    tbl.push_back(mk(0, 0, 0, 0,  2'b00, 0, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  2'b00, 0, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2'b00, 1, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 1, W1, 2'b00, 0, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2'b01, 0, 2'b01, 32'h11111111, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2'b01, 0, 2'b01, 32'h22222222, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2'b01, 0, 2'b01, 32'h33333333, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2'b01, 0, 2'b01, 32'h44444444, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2'b01, 0, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 1, W2, 2'b00, 0, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2'b00, 0, 2'b00, 32'h0,        0, 1));
    tbl.push_back(mk(1, 1, 0, 0,  2'b00, 0, 2'b00, 32'h0,        0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  2'b00, 0, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  2'b00, 0, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2'b00, 1, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  2'b00, 0, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 1, W2, 2'b00, 0, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  2'b01, 0, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2'b01, 1, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 1, W3, 2'b01, 0, 2'b00, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2'b01, 0, 2'b01, 32'hAAAA0001, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  2'b11, 0, 2'b00, 32'h0,        1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2'b11, 0, 2'b00, 32'h0,        0, 0));

    // reset values, with requests pending
    bus.ch_req = 2'b11;
    #12;
    check("rst_rd_sop", bus.rd_sop, 0);
    check("rst_ch_ack", bus.ch_ack, 0);
    check("rst_ch_data", bus.ch_data, 0);
    check("rst_level", level, 0);
    check("rst_src_err", src_err, 0);
    @(posedge clk); #1;
    bus.ch_req = '0;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      enable        = tbl[i].en;
      flush         = tbl[i].fl;
      bus.sop_valid = tbl[i].sv;
      bus.sop_data  = tbl[i].data;
      bus.ch_req    = tbl[i].req;
      @(negedge clk);
      check($sformatf("row%0d_rd_sop", i), bus.rd_sop, tbl[i].x_rd);
      check($sformatf("row%0d_ch_ack", i), bus.ch_ack, tbl[i].x_ack);
      check($sformatf("row%0d_ch_data", i), bus.ch_data, tbl[i].x_data);
      check($sformatf("row%0d_level", i), level, tbl[i].x_lvl);
      check($sformatf("row%0d_src_err", i), src_err, tbl[i].x_err);
      @(posedge clk); #1;
    end

    // scoreboarded fill with a 3-cycle RNG
    enable = 0; flush = 0; bus.sop_valid = 0; bus.ch_req = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    sb_on = 1; rng_on = 1; lat = 3;
    enable = 1;
    repeat (30) step();
    check("fill_level", level, DEPTH);
    check("fill_rd_count", cnt_rd, DEPTH);

    // both channels drain while refills land alongside final-slice pops
    lat = 2;
    bus.ch_req = 2'b11;
    repeat (24) step();
    enable = 0;
    for (int i = 0; i < 80 && (lvl_m != 0 || pend != 0 || out_m); i++) step();
    bus.ch_req = '0;
    step();
    check("drain_level", level, 0);
    check("drain_q_left", exp_q.size(), 0);
    check("drain_total", cnt_ch[0] + cnt_ch[1], words_sent * RATIO);
    d = cnt_ch[0] - cnt_ch[1];
    check("drain_balance", (d <= 1) && (d >= -1), 1);

    // async reset with a word buffered and a request in flight
    sb_on = 0; rng_on = 0;
    enable = 1;
    @(posedge clk); #1;
    enable = 0;
    @(negedge clk);
    check("mt_rd_first", bus.rd_sop, 1);
    @(posedge clk); #1;
    bus.sop_valid = 1; bus.sop_data = W1;
    @(posedge clk); #1;
    bus.sop_valid = 0;
    enable = 1;
    @(negedge clk);
    check("mt_level_one", level, 1);
    @(posedge clk); #1;
    enable = 0;
    bus.ch_req = 2'b01;
    @(negedge clk);
    check("mt_rd_second", bus.rd_sop, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mt_rst_rd_sop", bus.rd_sop, 0);
    check("mt_rst_level", level, 0);
    check("mt_rst_ack", bus.ch_ack, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.ch_req = '0;
    bus.sop_valid = 1; bus.sop_data = W3;
    @(posedge clk); #1;
    bus.sop_valid = 0;
    @(negedge clk);
    check("mt_late_src_err", src_err, 1);
    check("mt_late_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
